// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters:
//   port 0 : core load/store stage
//   port 1 : debug / DMA port
//
// The memory has a synchronous read (data appears on mem_rd the cycle after
// the address is presented) and a byte-enabled write. Read and write are
// mutually exclusive in a cycle, so one request is accepted per cycle at
// most.
//
// Arbitration is round-robin between the two ports. A requester can hold the
// grant across several requests (for an atomic read-modify-write) by setting
// req_lock. While a lock is held, the other port is never granted, even when
// the lock owner is idle. The owner releases the lock by issuing a request
// with req_lock=0.
//
// Every accepted request produces exactly one response, one cycle after the
// accept, on the port that issued it. A read returns mem_rd. A write returns
// an ack with rdata=0. Responses have no backpressure.
//
// Ports (pN_* exists for N = 0 and 1):
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   pN_req_valid   request valid
//   pN_req_ready   request accepted this cycle (valid && ready = accept)
//   pN_req_we      1 = write, 0 = read
//   pN_req_be      write byte enables (XLEN/8 bits)
//   pN_req_addr    word address
//   pN_req_wdata   write data
//   pN_req_lock    keep the grant on this port after this request
//   pN_rsp_valid   response valid (read data or write ack)
//   pN_rsp_rdata   read data, 0 for a write ack or when no response
//   mem_we         memory write enable
//   mem_be         memory byte enables
//   mem_addr       memory word address
//   mem_wd         memory write data
//   mem_rd         memory read data (registered inside the memory)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Port 0: core load/store
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [XLEN/8-1:0]     p0_req_be,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [XLEN-1:0]       p0_req_wdata,
    input  logic                  p0_req_lock,
    output logic                  p0_rsp_valid,
    output logic [XLEN-1:0]       p0_rsp_rdata,

    // Port 1: debug / DMA
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [XLEN/8-1:0]     p1_req_be,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [XLEN-1:0]       p1_req_wdata,
    input  logic                  p1_req_lock,
    output logic                  p1_rsp_valid,
    output logic [XLEN-1:0]       p1_rsp_rdata,

    // Memory pins
    output logic                  mem_we,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wd,
    input  logic [XLEN-1:0]       mem_rd
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    port_e r_rr_last;      // port granted by the most recent accept
    logic  r_lock_active;  // a lock is held
    port_e r_lock_owner;   // port holding the lock
    logic  r_rsp_pend;     // a response is due this cycle
    port_e r_rsp_port;     // port the due response belongs to
    logic  r_rsp_is_wr;    // due response is a write ack

    // -------------------------------------------------------------------------
    // Grant
    // -------------------------------------------------------------------------
    logic  w_grant_valid;
    port_e w_grant_port;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_grant_valid = 1'b0;
        w_grant_port  = PORT0;

        if (r_lock_active) begin
            // Only the owner may be granted; the other port waits even if the
            // owner is idle this cycle.
            w_grant_port  = r_lock_owner;
            w_grant_valid = (r_lock_owner == PORT0) ? p0_req_valid : p1_req_valid;
        end else if (p0_req_valid && p1_req_valid) begin
            // Contention: favour the port that did not win last time.
            w_grant_valid = 1'b1;
            w_grant_port  = (r_rr_last == PORT0) ? PORT1 : PORT0;
        end else if (p0_req_valid) begin
            w_grant_valid = 1'b1;
            w_grant_port  = PORT0;
        end else if (p1_req_valid) begin
            w_grant_valid = 1'b1;
            w_grant_port  = PORT1;
        end
    end

    // A grant is only ever given to a valid port, so grant == accept.
    logic w_accept;
    assign w_accept     = w_grant_valid;
    assign p0_req_ready = w_grant_valid && (w_grant_port == PORT0);
    assign p1_req_ready = w_grant_valid && (w_grant_port == PORT1);

    // -------------------------------------------------------------------------
    // Memory request mux
    // -------------------------------------------------------------------------
    logic w_acc_we;    // accepted request is a write
    logic w_acc_lock;  // accepted request asks to keep the lock

    always_comb begin
        // With no grant the pins sit at zero, which is a harmless read of
        // address 0.
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wd     = '0;
        w_acc_we   = 1'b0;
        w_acc_lock = 1'b0;

        if (w_grant_valid) begin
            if (w_grant_port == PORT0) begin
                mem_we     = p0_req_we;
                mem_be     = p0_req_we ? p0_req_be : '0;
                mem_addr   = p0_req_addr;
                mem_wd     = p0_req_we ? p0_req_wdata : '0;
                w_acc_we   = p0_req_we;
                w_acc_lock = p0_req_lock;
            end else begin
                mem_we     = p1_req_we;
                mem_be     = p1_req_we ? p1_req_be : '0;
                mem_addr   = p1_req_addr;
                mem_wd     = p1_req_we ? p1_req_wdata : '0;
                w_acc_we   = p1_req_we;
                w_acc_lock = p1_req_lock;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration, lock and response-tracking state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last     <= PORT0;
            r_lock_active <= 1'b0;
            r_lock_owner  <= PORT0;
            r_rsp_pend    <= 1'b0;
            r_rsp_port    <= PORT0;
            r_rsp_is_wr   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            // The response trackers follow the accept one cycle later and
            // clear on idle cycles.
            r_rsp_pend  <= w_accept;
            r_rsp_port  <= w_accept ? w_grant_port : PORT0;
            r_rsp_is_wr <= w_accept && w_acc_we;

            if (w_accept) begin
                r_rr_last <= w_grant_port;

                if (w_acc_lock) begin
                    r_lock_active <= 1'b1;
                    r_lock_owner  <= w_grant_port;
                end else if (r_lock_active && (w_grant_port == r_lock_owner)) begin
                    // The owner's unlocked request ends the locked sequence.
                    r_lock_active <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response routing
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] w_rsp_rdata;

    // Write acks carry zero. Read data comes straight from the memory's
    // output register, which was loaded on the accept edge.
    assign w_rsp_rdata  = (r_rsp_pend && !r_rsp_is_wr) ? mem_rd : '0;

    assign p0_rsp_valid = r_rsp_pend && (r_rsp_port == PORT0);
    assign p1_rsp_valid = r_rsp_pend && (r_rsp_port == PORT1);
    assign p0_rsp_rdata = p0_rsp_valid ? w_rsp_rdata : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? w_rsp_rdata : '0;

endmodule
